mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in BUSY waiting for m_ready before abort.
- REQ-002 Parameter D_BURST, default 2: consecutive D grants allowed while i_req is pending.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 i_req  input  1  fetch request level, held until i_valid.
- REQ-006 i_addr  input  32  fetch address.
- REQ-007 i_rdata  output  32  fetched instruction.
- REQ-008 i_valid  output  1  one-cycle fetch completion pulse.
- REQ-009 d_req  input  1  data request level, held until d_valid.
- REQ-010 d_we  input  1  1 = store, 0 = load.
- REQ-011 d_addr  input  32  data address.
- REQ-012 d_wdata  input  32  store data.
- REQ-013 d_rdata  output  32  load data.
- REQ-014 d_valid  output  1  one-cycle data completion pulse, for loads and stores.
- REQ-015 m_req  output  1  shared memory request.
- REQ-016 m_we  output  1  shared memory write enable.
- REQ-017 m_addr  output  32  shared memory address.
- REQ-018 m_wdata  output  32  shared memory write data.
- REQ-019 m_rdata  input  32  shared memory read data.
- REQ-020 m_ready  input  1  memory completion, sampled only while m_req=1.
- REQ-021 timeout_err  output  1  sticky abort flag.

Function
- REQ-022 The FSM SHALL have states IDLE, BUSY and DONE, plus an owner register (I or D).
- REQ-023 IDLE SHALL grant D when d_req=1, unless the burst counter equals D_BURST and i_req=1, in which case it SHALL grant I.
- REQ-024 IDLE SHALL grant I when i_req=1 and d_req=0.
- REQ-025 IDLE SHALL stay in IDLE when no request is present.
- REQ-026 On a grant, the block SHALL register the owner, address, we (0 for I) and wdata, and move to BUSY.
- REQ-027 In BUSY, m_req SHALL be 1 and m_addr/m_we/m_wdata SHALL come from registers, stable for the whole transaction.
- REQ-028 In BUSY with m_ready=1, the block SHALL capture m_rdata into the owner's rdata (D loads only; D stores leave d_rdata unchanged) and move to DONE.
- REQ-029 DONE SHALL assert the owner's valid for exactly one cycle, then return to IDLE; requests are not sampled in DONE.
- REQ-030 Minimum latency from request seen in IDLE to valid SHALL be 2 cycles (grant edge, BUSY with m_ready=1, DONE).
- REQ-031 The burst counter SHALL increment on each D grant made while i_req=1, saturate at D_BURST, and clear on any I grant or when i_req=0 in IDLE.
- REQ-032 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle with m_ready=0.
- REQ-033 When the wait counter reaches TIMEOUT, the block SHALL set timeout_err, load 0 into the owner's rdata, and go to DONE (valid still pulses).
- REQ-034 If m_ready and the timeout occur in the same cycle, m_ready SHALL win and no error is flagged.
- REQ-035 m_req, i_valid and d_valid SHALL be 0 in IDLE; i_valid and d_valid SHALL never both be 1.

Reset
- REQ-036 Reset SHALL asynchronously force IDLE, owner I, both counters 0, m_req/m_we/i_valid/d_valid/timeout_err 0, and all address, data and rdata registers 0.
- REQ-037 Reset mid-transaction SHALL abandon the transaction with no valid pulse; m_req SHALL drop in the reset cycle.
- REQ-038 timeout_err SHALL clear only on reset.

Structure
- REQ-039 Package mem_arb_pkg SHALL hold the state enum (IDLE, BUSY, DONE), the owner enum (OWN_I, OWN_D) and the default TIMEOUT and D_BURST constants.
- REQ-040 The block SHALL be a single module with no sub-modules; the counters are inline.

Verification
- REQ-041 Lone fetch: i_req, i_addr=0x10, m_ready on the first BUSY cycle with m_rdata=0x00500113 -> i_valid 2 cycles after request, i_rdata=0x00500113, m_we=0.
- REQ-042 Store: d_req, d_we=1, d_addr=0xBC, d_wdata=25 -> m_req with m_addr=0xBC, m_wdata=25, m_we=1, then d_valid, with d_rdata unchanged.
- REQ-043 Contention: i_req and d_req both held continuously -> grant order D, D, I, D, D, I.
- REQ-044 Timeout: i_req with m_ready held at 0 -> i_valid after TIMEOUT+1 BUSY cycles, i_rdata=0, timeout_err=1 until reset.
- REQ-045 Reset asserted mid-BUSY with a D load -> m_req=0 immediately, no d_valid, and state IDLE after reset deasserts.
- REQ-046 m_ready delayed 5 cycles -> m_addr/m_wdata stable throughout BUSY, and exactly one valid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default parameters for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int TIMEOUT_DEF = 255;
  localparam int D_BURST_DEF = 2;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int D_BURST = D_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 2);
  localparam int BW = $clog2(D_BURST + 2);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);
  localparam logic [BW-1:0] D_BURST_B = BW'(D_BURST);

  state_t        state, state_n;
  owner_t        owner;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic [31:0]   addr_q, wdata_q;
  logic          we_q;
  logic          grant_d, grant_i, wait_expired;

  // D wins ties until it has used up its burst while a fetch is waiting
  always_comb begin
    state_n      = state;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    wait_expired = (wait_cnt == TIMEOUT_W);
    case (state)
      IDLE: begin
        if (d_req && !(burst_cnt == D_BURST_B && i_req)) begin
          grant_d = 1'b1;
          state_n = BUSY;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY:    if (m_ready || wait_expired) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      wait_cnt    <= '0;
      burst_cnt   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        wait_cnt <= '0;
        if (grant_d) begin
          owner   <= OWN_D;
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
          if (!i_req)
            burst_cnt <= '0;
          else if (burst_cnt != D_BURST_B)
            burst_cnt <= burst_cnt + BW'(1);
        end else begin
          burst_cnt <= '0;
          if (grant_i) begin
            owner   <= OWN_I;
            addr_q  <= i_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end
        end
      end else if (state == BUSY) begin
        // a completion in the same cycle as expiry is a normal completion
        if (m_ready) begin
          if (owner == OWN_I)
            i_rdata <= m_rdata;
          else if (!we_q)
            d_rdata <= m_rdata;
        end else if (wait_expired) begin
          timeout_err <= 1'b1;
          if (owner == OWN_I)
            i_rdata <= '0;
          else
            d_rdata <= '0;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
        end
      end
    end
  end

  assign m_req   = (state == BUSY);
  assign m_we    = (state == BUSY) && we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_valid = (state == DONE) && (owner == OWN_I);
  assign d_valid = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
import mem_arb_pkg::*;

module tb_mem_arbiter;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_valid, d_valid, m_req, m_we, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.TIMEOUT(TMO), .D_BURST(2)) dut (
    .clk(clk), .reset(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants[6];
  int n_grant, both_hi, unstable, pulses, busy;
  logic found;

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    step(); step();
    check("rst_m_req",   32'(m_req), 0);
    check("rst_m_we",    32'(m_we), 0);
    check("rst_valids",  32'({i_valid, d_valid}), 0);
    check("rst_err",     32'(timeout_err), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_m_addr",  m_addr, 0);
    rst = 1'b0;
    step();

    // lone fetch, ready on first BUSY cycle
    i_req = 1; i_addr = 32'h10; m_ready = 1; m_rdata = 32'h00500113;
    step();
    check("fetch_m_req",  32'(m_req), 1);
    check("fetch_m_addr", m_addr, 32'h10);
    check("fetch_m_we",   32'(m_we), 0);
    step();
    check("fetch_valid",  32'(i_valid), 1);
    check("fetch_rdata",  i_rdata, 32'h00500113);
    check("fetch_dvalid", 32'(d_valid), 0);
    i_req = 0;
    step();
    check("fetch_idle",   32'({i_valid, m_req}), 0);

    // load to give d_rdata a known non-zero value
    d_req = 1; d_we = 0; d_addr = 32'h40; m_rdata = 32'hCAFE0001;
    step(); step();
    check("load_valid", 32'(d_valid), 1);
    check("load_rdata", d_rdata, 32'hCAFE0001);
    d_req = 0;
    step();

    // store leaves d_rdata alone
    d_req = 1; d_we = 1; d_addr = 32'hBC; d_wdata = 32'd25; m_rdata = 32'hDEADBEEF;
    step();
    check("st_m_req",   32'(m_req), 1);
    check("st_m_addr",  m_addr, 32'hBC);
    check("st_m_wdata", m_wdata, 32'd25);
    check("st_m_we",    32'(m_we), 1);
    step();
    check("st_valid",   32'(d_valid), 1);
    check("st_rdata",   d_rdata, 32'hCAFE0001);
    d_req = 0; d_we = 0;
    step();

    // contention: expect D D I D D I
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; m_ready = 1;
    n_grant = 0; both_hi = 0;
    for (int c = 0; c < 40 && n_grant < 6; c++) begin
      step();
      if (i_valid && d_valid) both_hi++;
      if (i_valid || d_valid) begin
        grants[n_grant] = d_valid ? 1 : 0;
        n_grant++;
      end
    end
    i_req = 0; d_req = 0;
    check("cont_count", 32'(n_grant), 6);
    check("cont_excl",  32'(both_hi), 0);
    check("cont_order", {26'd0, 32'(grants[0]) != 0, 32'(grants[1]) != 0, 32'(grants[2]) != 0,
                         32'(grants[3]) != 0, 32'(grants[4]) != 0, 32'(grants[5]) != 0},
          32'b110110);
    step();

    // m_ready delayed five cycles; inputs wander meanwhile
    m_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h88; d_wdata = 32'h77;
    step();
    d_addr = 32'hFFFF_0000; d_wdata = 32'h0000_FFFF;
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      if (!m_req || m_addr !== 32'h88 || m_wdata !== 32'h77) unstable++;
      step();
    end
    if (!m_req || m_addr !== 32'h88 || m_wdata !== 32'h77) unstable++;
    m_ready = 1; m_rdata = 32'h12345678;
    step();
    d_req = 0; m_ready = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (d_valid) pulses++;
      if (i_valid) pulses += 100;
      step();
    end
    check("dly_stable", 32'(unstable), 0);
    check("dly_pulses", 32'(pulses), 1);
    check("dly_rdata",  d_rdata, 32'h12345678);

    // m_ready on the very cycle the wait expires wins
    i_req = 1; i_addr = 32'h20; m_ready = 0;
    step();
    repeat (TMO) step();
    check("tie_m_req", 32'(m_req), 1);
    m_ready = 1; m_rdata = 32'hA5A5A5A5;
    step();
    check("tie_valid", 32'(i_valid), 1);
    check("tie_rdata", i_rdata, 32'hA5A5A5A5);
    check("tie_err",   32'(timeout_err), 0);
    i_req = 0; m_ready = 0;
    step();

    // true timeout
    i_req = 1; i_addr = 32'h30; busy = 0; found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (m_req) busy++;
      if (i_valid) found = 1;
    end
    i_req = 0;
    check("tmo_found", 32'(found), 1);
    check("tmo_busy",  32'(busy), 32'(TMO + 1));
    check("tmo_rdata", i_rdata, 0);
    check("tmo_err",   32'(timeout_err), 1);
    repeat (5) step();
    check("tmo_sticky", 32'(timeout_err), 1);

    // reset in the middle of a D load
    d_req = 1; d_we = 0; d_addr = 32'h44; m_ready = 0;
    step();
    check("mid_m_req", 32'(m_req), 1);
    #2 rst = 1'b1;
    #1 check("mid_rst_m_req", 32'(m_req), 0);
    d_req = 0;
    step();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (d_valid || i_valid || m_req) pulses++;
    end
    check("mid_quiet", 32'(pulses), 0);
    check("mid_state", 32'(dut.state), 32'(IDLE));
    check("mid_err",   32'(timeout_err), 0);
    check("mid_rdata", d_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
